// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SENT  = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } ccff_state_t;

    // Default sentinel; bit 0 enters the chain first.
    localparam logic [3:0] DEF_SENTINEL = 4'b1010;

    // Number of bitstream words needed to cover the chain.
    function automatic int ccff_nw(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_piso.sv
// Word parallel-in/serial-out register with a count of valid bits still to shift.
// Latency: loaded bits appear on ser_bit the cycle after load; one bit per shift.
// Backpressure: none internally; the caller loads only when empty or on the last bit.
//
// Ports: prog_clk/prog_reset clock and async reset; load/din/nbits capture a word
// with nbits valid bits (load wins over shift); shift drops the current bit;
// ser_bit is the current bit, empty/last flag zero/one valid bits remaining.
module ccff_word_piso #(
    parameter int WORD_W = 8,
    parameter int NB_W   = $clog2(WORD_W + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    input  logic [NB_W-1:0]   nbits,
    input  logic              shift,
    output logic              ser_bit,
    output logic              empty,
    output logic              last
);

    logic [WORD_W-1:0] data;
    logic [NB_W-1:0]   cnt;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= din;
            cnt  <= nbits;
        end else if (shift && (cnt != '0)) begin
            data <= data >> 1;
            cnt  <= cnt - NB_W'(1);
        end
    end

    assign ser_bit = data[0];
    assign empty   = (cnt == '0);
    assign last    = (cnt == NB_W'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises a bitstream into the configuration chain behind a sentinel, then checks the sentinel at ccff_tail.
// Latency: start to cfg_done is SENT_LEN+CHAIN_LEN+3 cycles when words arrive without gaps.
// Backpressure: bs_ready only in LOAD while the serializer is empty or on its last bit; stalls hold all counters.
//
// Ports: prog_clk, prog_reset (async, active high); start pulse; bs_valid/bs_data/bs_ready word stream;
// ccff_head/ccff_shift_en registered chain drive; ccff_tail chain return; busy, cfg_done, error status.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int                  CHAIN_LEN = 66,
    parameter int                  WORD_W    = 8,
    parameter int                  SENT_LEN  = 4,
    parameter logic [SENT_LEN-1:0] SENTINEL  = DEF_SENTINEL
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              cfg_done,
    output logic              error
);

    localparam int TOTAL   = SENT_LEN + CHAIN_LEN;
    localparam int NW      = ccff_nw(CHAIN_LEN, WORD_W);
    localparam int CW      = $clog2(TOTAL + 1);
    localparam int WCW     = $clog2(NW + 1);
    localparam int NBW     = $clog2(WORD_W + 1);
    localparam int LAST_NB = CHAIN_LEN - (NW - 1) * WORD_W;

    ccff_state_t     state;
    logic [CW-1:0]   icnt;      // shifts issued so far (value of the shift now on ccff_head)
    logic [WCW-1:0]  wcnt;      // words accepted so far
    logic            mismatch;

    logic              p_load, p_shift, p_bit, p_empty, p_last;
    logic [WORD_W-1:0] p_din;
    logic [NBW-1:0]    p_nbits, word_nb;
    logic              load_act, accept;
    logic [CW-1:0]     tail_idx;
    logic              sent_bit, tail_exp;

    // The final word only carries the bits that still fit in the chain.
    assign word_nb  = (wcnt == WCW'(NW - 1)) ? NBW'(LAST_NB) : NBW'(WORD_W);
    assign load_act = (state == LOAD) && (icnt < CW'(TOTAL));
    assign bs_ready = load_act && (wcnt < WCW'(NW)) && (p_empty || p_last);
    assign accept   = bs_valid && bs_ready;

    // Sentinel bit to issue next, and the one expected back at the tail for the shift in flight.
    assign tail_idx = icnt - CW'(CHAIN_LEN + 1);
    assign sent_bit = |(SENTINEL & (SENT_LEN'(1) << icnt));
    assign tail_exp = |(SENTINEL & (SENT_LEN'(1) << tail_idx));

    // A word accepted while empty has its bit 0 sent straight to ccff_head, so the
    // serializer keeps only the remaining bits; this avoids a bubble on the first word.
    always_comb begin
        p_load  = accept;
        p_shift = load_act && !p_empty;
        p_din   = bs_data;
        p_nbits = word_nb;
        if (p_empty) begin
            p_din   = bs_data >> 1;
            p_nbits = word_nb - NBW'(1);
        end
    end

    ccff_word_piso #(
        .WORD_W (WORD_W),
        .NB_W   (NBW)
    ) u_piso (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .load       (p_load),
        .din        (p_din),
        .nbits      (p_nbits),
        .shift      (p_shift),
        .ser_bit    (p_bit),
        .empty      (p_empty),
        .last       (p_last)
    );

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state         <= IDLE;
            icnt          <= '0;
            wcnt          <= '0;
            mismatch      <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            cfg_done      <= 1'b0;
            error         <= 1'b0;
        end else begin
            ccff_shift_en <= 1'b0;

            // Tail is compared on the edge that completes each of the last SENT_LEN shifts.
            if (ccff_shift_en && (icnt > CW'(CHAIN_LEN)) && (ccff_tail != tail_exp))
                mismatch <= 1'b1;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state         <= SENT;
                        busy          <= 1'b1;
                        cfg_done      <= 1'b0;
                        error         <= 1'b0;
                        mismatch      <= 1'b0;
                        wcnt          <= '0;
                        icnt          <= CW'(1);
                        ccff_head     <= SENTINEL[0];
                        ccff_shift_en <= 1'b1;
                    end
                end
                SENT: begin
                    if (icnt < CW'(SENT_LEN)) begin
                        ccff_head     <= sent_bit;
                        ccff_shift_en <= 1'b1;
                        icnt          <= icnt + CW'(1);
                    end
                    if (icnt >= CW'(SENT_LEN - 1))
                        state <= LOAD;
                end
                LOAD: begin
                    if (load_act) begin
                        if (!p_empty) begin
                            ccff_head     <= p_bit;
                            ccff_shift_en <= 1'b1;
                            icnt          <= icnt + CW'(1);
                        end else if (accept) begin
                            ccff_head     <= bs_data[0];
                            ccff_shift_en <= 1'b1;
                            icnt          <= icnt + CW'(1);
                        end
                        if (accept)
                            wcnt <= wcnt + WCW'(1);
                    end else if (!ccff_shift_en) begin
                        // Wait for the final shift (and its tail sample) to complete.
                        state <= CHECK;
                        busy  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        state    <= DONE;
                        cfg_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench for ccff_bitstream_loader with a behavioural configuration chain.
// Latency: n/a (testbench).
// Backpressure: the word source honours bs_ready and can withhold words to force stalls.
module tb_ccff_bitstream_loader;

    localparam int CHAIN_LEN = 66;
    localparam int WORD_W    = 8;

    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic       start;
    logic       bs_valid;
    logic [7:0] bs_data;
    logic       bs_ready;
    logic       ccff_head;
    logic       ccff_shift_en;
    logic       ccff_tail;
    logic       busy;
    logic       cfg_done;
    logic       error;

    int checks = 0;
    int errors = 0;

    // Behavioural chain: ch[0] is the flop fed by ccff_head.
    int         model_len = 66;
    bit         stuck     = 1'b0;
    logic [69:0] ch;

    always @(posedge prog_clk) if (ccff_shift_en) ch <= {ch[68:0], ccff_head};
    assign ccff_tail = stuck ? 1'b0 : ch[model_len-1];

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .bs_valid      (bs_valid),
        .bs_data       (bs_data),
        .bs_ready      (bs_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .cfg_done      (cfg_done),
        .error         (error)
    );

    typedef struct {
        int len;
        bit stuck;
        bit stall;
        int restart_at;
        bit exp_done;
        bit exp_err;
        int exp_lat;
        int exp_span;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Flop p must hold bitstream bit 65-p; bitstream bit b is bit b%8 of word value b/8+1.
    function automatic int chain_errs();
        int n = 0;
        for (int p = 0; p < CHAIN_LEN; p++) begin
            int b = CHAIN_LEN - 1 - p;
            logic [7:0] w = 8'(b / 8 + 1);
            if (ch[p] !== w[b % 8]) n++;
        end
        return n;
    endfunction

    // Runs one load. Cycle 0 is the start cycle; lat is the first cycle showing cfg_done or error.
    task automatic run_load(input int id, input vec_t v,
                            output int lat, output int nsh, output int span, output int nacc);
        int  first, last_c, hold, widx;
        bit  restarted;
        model_len = v.len;
        stuck     = v.stuck;
        @(negedge prog_clk);
        start    = 1'b1;
        bs_valid = 1'b1;
        bs_data  = 8'h01;
        chk($sformatf("v%0d_rdy_at_start", id), bs_ready, 0);
        @(negedge prog_clk);
        start = 1'b0;
        chk($sformatf("v%0d_status_c1", id), {busy, cfg_done, error}, 3'b100);
        lat = -1; nsh = 0; first = -1; last_c = -1; hold = 0; widx = 0; nacc = 0; restarted = 1'b0;
        for (int c = 1; c < 400; c++) begin
            start = 1'b0;
            if (v.restart_at >= 0 && !restarted && nsh == v.restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (hold > 0) begin
                bs_valid = 1'b0;
                hold--;
            end else begin
                bs_valid = 1'b1;
                bs_data  = 8'(widx + 1);
            end
            if (ccff_shift_en) begin
                nsh++;
                if (first < 0) first = c;
                last_c = c;
            end
            if (cfg_done || error) begin
                lat = c;
                break;
            end
            if (bs_valid && bs_ready) begin
                nacc++;
                widx++;
                // Withhold the next word through the 8-bit drain plus 5 idle cycles.
                if (v.stall && (widx == 2 || widx == 7)) hold = WORD_W + 5;
            end
            @(negedge prog_clk);
        end
        start    = 1'b0;
        bs_valid = 1'b1;
        bs_data  = 8'h0A;
        chk($sformatf("v%0d_rdy_after", id), bs_ready, 0);
        span = (first < 0) ? 0 : last_c - first + 1;
    endtask

    initial begin
        int lat, nsh, span, nacc, n, guard;

        // len, stuck, stall, restart_at, exp_done, exp_err, exp_lat, exp_span
        vecs[0] = '{66, 1'b0, 1'b0, -1, 1'b1, 1'b0, 73, 70};  // nominal
        vecs[1] = '{66, 1'b0, 1'b1, -1, 1'b1, 1'b0, 83, 80};  // two 5-cycle stalls
        vecs[2] = '{65, 1'b0, 1'b0, -1, 1'b0, 1'b1, 73, 70};  // chain one flop short
        vecs[3] = '{66, 1'b0, 1'b0, -1, 1'b1, 1'b0, 73, 70};  // recovery from ERR
        vecs[4] = '{66, 1'b1, 1'b0, -1, 1'b0, 1'b1, 73, 70};  // tail stuck at 0
        vecs[5] = '{66, 1'b0, 1'b0, 40, 1'b1, 1'b0, 73, 70};  // start during LOAD ignored

        prog_reset = 1'b1;
        start      = 1'b0;
        bs_valid   = 1'b0;
        bs_data    = 8'h00;
        repeat (3) @(negedge prog_clk);
        chk("reset_outputs", {bs_ready, ccff_head, ccff_shift_en, busy, cfg_done, error}, 6'b0);
        prog_reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_load(i, vecs[i], lat, nsh, span, nacc);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_cfg_done", i), cfg_done, vecs[i].exp_done);
            chk($sformatf("v%0d_error", i), error, vecs[i].exp_err);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_shift_count", i), nsh, 70);
            chk($sformatf("v%0d_shift_span", i), span, vecs[i].exp_span);
            chk($sformatf("v%0d_words_accepted", i), nacc, 9);
            if (vecs[i].len == CHAIN_LEN && !vecs[i].stuck)
                chk($sformatf("v%0d_chain_bits_wrong", i), chain_errs(), 0);
        end

        // Reset in the middle of a load.
        model_len = 66;
        stuck     = 1'b0;
        @(negedge prog_clk);
        start    = 1'b1;
        bs_valid = 1'b0;
        @(negedge prog_clk);
        start    = 1'b0;
        bs_valid = 1'b1;
        bs_data  = 8'hA5;
        n = ccff_shift_en ? 1 : 0;
        guard = 0;
        while (n < 30 && guard < 200) begin
            @(negedge prog_clk);
            guard++;
            if (ccff_shift_en) n++;
        end
        chk("abort_shifts_reached", n, 30);
        #2 prog_reset = 1'b1;
        #1;
        chk("abort_async_outputs", {bs_ready, ccff_head, ccff_shift_en, busy, cfg_done, error}, 6'b0);
        @(negedge prog_clk);
        prog_reset = 1'b0;
        bs_valid   = 1'b0;
        run_load(6, vecs[0], lat, nsh, span, nacc);
        chk("abort_reload_latency", lat, 73);
        chk("abort_reload_cfg_done", cfg_done, 1);
        chk("abort_reload_error", error, 0);
        chk("abort_reload_shift_count", nsh, 70);
        chk("abort_reload_chain_bits_wrong", chain_errs(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
